// File: rtl/if_else_emitter.sv
// Serialises "if x<OP><valc> p<=<const1> else p<=<const2><TERM_CHAR>" as a 7-bit ASCII stream.
// Handshake: a character moves when char_valid & char_ready; while unaccepted it is held stable.
module if_else_emitter #(
  parameter int         VAL_W     = 32,
  parameter logic [6:0] TERM_CHAR = 7'h3B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       comparator,
  input  logic [VAL_W-1:0] valc,
  input  logic [VAL_W-1:0] const1,
  input  logic [VAL_W-1:0] const2,
  output logic [6:0]       ascii_char,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done,
  output logic             error_flag,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_KW, S_OP, S_NUM_C, S_SEP1, S_NUM_1, S_SEP2, S_NUM_2, S_TERM
  } state_t;

  state_t           state_q, state_n;
  logic [2:0]       cmp_q;
  logic [VAL_W-1:0] valc_q, c1_q, c2_q;
  logic [3:0]       idx_q, idx_n;
  logic [63:0]      rem_q, rem_n;
  logic [3:0]       pow_q, pow_n;
  logic             neg_q, neg_n;
  logic             done_q, done_n;
  logic             err_q, err_n;

  logic             accept, xfer, last, is_num, is_entry;
  logic [7:0]       ch;
  logic [VAL_W-1:0] entry_val, entry_mag;
  logic [3:0]       entry_pow, digit;
  logic [63:0]      step;

  function automatic logic [63:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    pow10 = 64'd1;
      4'd1:    pow10 = 64'd10;
      4'd2:    pow10 = 64'd100;
      4'd3:    pow10 = 64'd1000;
      4'd4:    pow10 = 64'd10000;
      4'd5:    pow10 = 64'd100000;
      4'd6:    pow10 = 64'd1000000;
      4'd7:    pow10 = 64'd10000000;
      4'd8:    pow10 = 64'd100000000;
      4'd9:    pow10 = 64'd1000000000;
      default: pow10 = 64'd0;
    endcase
  endfunction

  assign accept     = (state_q == S_IDLE) && start;
  assign char_valid = (state_q != S_IDLE);
  assign xfer       = char_valid && char_ready;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error_flag = err_q;
  assign dbg_state  = state_q;
  assign ascii_char = ch[6:0];
  assign is_num     = (state_q == S_NUM_C) || (state_q == S_NUM_1) || (state_q == S_NUM_2);
  assign is_entry   = (state_q == S_OP) || (state_q == S_SEP1) || (state_q == S_SEP2);

  // Operand of the numeric field about to be entered, prepared so its first char has no bubble.
  always_comb begin
    case (state_q)
      S_SEP1:  entry_val = c1_q;
      S_SEP2:  entry_val = c2_q;
      default: entry_val = valc_q;
    endcase
    entry_mag = entry_val[VAL_W-1] ? ((~entry_val) + VAL_W'(1)) : entry_val;
    entry_pow = 4'd0;
    for (int i = 1; i < 10; i++)
      if (64'(entry_mag) >= pow10(4'(i))) entry_pow = 4'(i);
  end

  always_comb begin
    digit = 4'd0;
    step  = 64'd0;
    for (int d = 1; d < 10; d++)
      if (rem_q >= 64'(d) * pow10(pow_q)) begin
        digit = 4'(d);
        step  = 64'(d) * pow10(pow_q);
      end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    rem_n   = rem_q;
    pow_n   = pow_q;
    neg_n   = neg_q;
    done_n  = 1'b0;
    err_n   = err_q;
    ch      = 8'h00;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_n = (comparator[2:1] == 2'b11);
          idx_n = 4'd0;
          if (comparator[2:1] != 2'b11) state_n = S_KW;
        end
      end
      S_KW: begin
        case (idx_q)
          4'd0:    ch = "i";
          4'd1:    ch = "f";
          4'd2:    ch = " ";
          default: ch = "x";
        endcase
        last = (idx_q == 4'd3);
      end
      S_OP: begin
        if (idx_q == 4'd0) begin
          case (cmp_q)
            3'b000:         ch = "=";
            3'b001:         ch = "!";
            3'b010, 3'b100: ch = "<";
            default:        ch = ">";
          endcase
        end else begin
          ch = "=";
        end
        last = (cmp_q == 3'b010 || cmp_q == 3'b011) ? (idx_q == 4'd0) : (idx_q == 4'd1);
      end
      S_SEP1: begin
        case (idx_q)
          4'd0:    ch = " ";
          4'd1:    ch = "p";
          4'd2:    ch = "<";
          default: ch = "=";
        endcase
        last = (idx_q == 4'd3);
      end
      S_SEP2: begin
        case (idx_q)
          4'd0, 4'd5: ch = " ";
          4'd1, 4'd4: ch = "e";
          4'd2:       ch = "l";
          4'd3:       ch = "s";
          4'd6:       ch = "p";
          4'd7:       ch = "<";
          default:    ch = "=";
        endcase
        last = (idx_q == 4'd8);
      end
      S_TERM: begin
        ch   = {1'b0, TERM_CHAR};
        last = 1'b1;
      end
      default: begin
        ch   = neg_q ? "-" : (8'h30 + {4'd0, digit});
        last = !neg_q && (pow_q == 4'd0);
      end
    endcase

    if (xfer) begin
      idx_n = idx_q + 4'd1;
      if (is_num) begin
        if (neg_q) neg_n = 1'b0;
        else begin
          rem_n = rem_q - step;
          if (pow_q != 4'd0) pow_n = pow_q - 4'd1;
        end
      end
      if (last) begin
        idx_n = 4'd0;
        if (is_entry) begin
          rem_n = 64'(entry_mag);
          pow_n = entry_pow;
          neg_n = entry_val[VAL_W-1];
        end
        case (state_q)
          S_KW:    state_n = S_OP;
          S_OP:    state_n = S_NUM_C;
          S_NUM_C: state_n = S_SEP1;
          S_SEP1:  state_n = S_NUM_1;
          S_NUM_1: state_n = S_SEP2;
          S_SEP2:  state_n = S_NUM_2;
          S_NUM_2: state_n = S_TERM;
          default: begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      pow_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cmp_q   <= '0;
      valc_q  <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      rem_q   <= rem_n;
      pow_q   <= pow_n;
      neg_q   <= neg_n;
      done_q  <= done_n;
      err_q   <= err_n;
      if (accept) begin
        cmp_q  <= comparator;
        valc_q <= valc;
        c1_q   <= const1;
        c2_q   <= const2;
      end
    end
  end

endmodule

// File: tb/tb_if_else_emitter.sv
// Bench for if_else_emitter: expected text is built with $sformatf from the operands and
// checked character by character as it is transferred; a small parser evaluates loopback output.
module tb_if_else_emitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  comparator = '0;
  logic [31:0] valc = '0, const1 = '0, const2 = '0;
  logic [6:0]  ascii_char;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        busy, done, error_flag;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [6:0] exp_q[$];
  byte        cap_q[$];
  logic       prev_hold = 1'b0;
  logic [6:0] prev_char = '0;

  if_else_emitter #(.VAL_W(32), .TERM_CHAR(7'h3B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .comparator(comparator),
    .valc(valc), .const1(const1), .const2(const2),
    .ascii_char(ascii_char), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .done(done), .error_flag(error_flag), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic string model_str(input logic [2:0] cmp, input int v, input int c1, input int c2);
    string op;
    case (cmp)
      3'd0:    op = "==";
      3'd1:    op = "!=";
      3'd2:    op = "<";
      3'd3:    op = ">";
      3'd4:    op = "<=";
      default: op = ">=";
    endcase
    return $sformatf("if x%s%0d p<=%0d else p<=%0d;", op, v, c1, c2);
  endfunction

  function automatic int read_num(input byte q[$], inout int k);
    int  val = 0;
    bit  neg = 0;
    if (k < q.size() && q[k] == "-") begin
      neg = 1;
      k++;
    end
    while (k < q.size() && q[k] >= "0" && q[k] <= "9") begin
      val = val * 10 + int'(q[k] - "0");
      k++;
    end
    return neg ? -val : val;
  endfunction

  // Statement-parser stand-in: evaluates the received text for a given x.
  function automatic int parse_p(input byte q[$], input int x);
    int  k = 4;
    byte first;
    bit  sec, cond;
    int  a, b, c;
    first = q[k];
    k++;
    sec = (q[k] == "=");
    if (sec) k++;
    a = read_num(q, k);
    k += 4;
    b = read_num(q, k);
    k += 9;
    c = read_num(q, k);
    case (first)
      "=":     cond = (x == a);
      "!":     cond = (x != a);
      "<":     cond = sec ? (x <= a) : (x < a);
      default: cond = sec ? (x >= a) : (x > a);
    endcase
    return cond ? b : c;
  endfunction

  // scoreboard: every transferred char, hold stability, done timing
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        total++;
        if (!char_valid || ascii_char !== prev_char) begin
          bad++;
          $display("FAIL hold: valid=%0b char=%02h expected valid=1 char=%02h", char_valid, ascii_char, prev_char);
        end
      end
      if (char_valid && char_ready) begin
        total++;
        cap_q.push_back(byte'({1'b0, ascii_char}));
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL char: unexpected char %02h with nothing expected", ascii_char);
        end else begin
          logic [6:0] e;
          e = exp_q.pop_front();
          if (ascii_char !== e) begin
            bad++;
            $display("FAIL char: got %02h expected %02h", ascii_char, e);
          end
        end
      end
      if (done) begin
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL done: remaining=%0d busy=%0b expected remaining=0 busy=0", exp_q.size(), busy);
        end
      end
      prev_hold = char_valid && !char_ready;
      prev_char = ascii_char;
    end
  end

  task automatic push_expected(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte b;
      b = s[i];
      exp_q.push_back(b[6:0]);
    end
  endtask

  // Drives one statement; returns the cycle (1 = cycle after accept) in which done was seen.
  task automatic run_stmt(input logic [2:0] cmp, input int v, input int c1, input int c2,
                          input bit rnd, output int done_cyc);
    push_expected(model_str(cmp, v, c1, c2));
    @(posedge clk); #1;
    start = 1'b1; comparator = cmp; valc = v; const1 = c1; const2 = c2;
    @(posedge clk); #1;
    start = 1'b0; valc = $urandom; const1 = $urandom; const2 = $urandom; comparator = 3'($urandom_range(0, 5));
    done_cyc = 0;
    for (int n = 1; n <= 3000 && done_cyc == 0; n++) begin
      char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (n == 3) begin start = 1'b1; comparator = 3'b110; end
      if (n == 4) start = 1'b0;
      @(negedge clk);
      if (done) done_cyc = n;
      @(posedge clk); #1;
    end
    start = 1'b0;
    char_ready = 1'b1;
    check("done_seen", longint'(done_cyc != 0), 1);
    check("err_after_stmt", error_flag, 0);
    if (done_cyc == 0) exp_q.delete();
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return int'(32'h8000_0000);
      2:       return 32'h7fff_ffff;
      3:       return int'($urandom_range(0, 20)) - 10;
      4:       return int'($urandom);
      default: return -int'($urandom_range(0, 99999));
    endcase
  endfunction

  initial begin
    int dc;
    int exp_p[6] = '{1, -1, -1, -1, 1, 1};
    string s1;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_char", ascii_char, 0);
    check("rst_valid", char_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error_flag, 0);
    rst_n = 1'b1;

    // model pins
    check_str("model_le", model_str(3'd4, 5, 3, -2), "if x<=5 p<=3 else p<=-2;");
    check_str("model_gt", model_str(3'd3, 0, int'(32'h8000_0000), 32'h7fff_ffff),
              "if x>0 p<=-2147483648 else p<=2147483647;");

    // 1: LE, 24 chars, done in cycle 25
    run_stmt(3'd4, 5, 3, -2, 1'b0, dc);
    check("case1_done_cycle", dc, 25);

    // 2: extreme values
    s1 = model_str(3'd3, 0, int'(32'h8000_0000), 32'h7fff_ffff);
    run_stmt(3'd3, 0, int'(32'h8000_0000), 32'h7fff_ffff, 1'b0, dc);
    check("case2_done_cycle", dc, s1.len() + 1);

    // 3: case 1 under random backpressure
    run_stmt(3'd4, 5, 3, -2, 1'b1, dc);

    // 4: invalid comparator
    for (int k = 0; k < 2; k++) begin
      int seen;
      @(posedge clk); #1;
      start = 1'b1; comparator = (k == 0) ? 3'b110 : 3'b111;
      @(posedge clk); #1;
      start = 1'b0;
      check("err_set", error_flag, 1);
      check("err_busy", busy, 0);
      seen = 0;
      repeat (5) begin
        @(negedge clk);
        if (char_valid || done) seen++;
      end
      check("err_quiet", seen, 0);
      run_stmt(3'd0, 1, 2, 3, 1'b0, dc);
      check("err_cleared", error_flag, 0);
    end

    // 5: reset after 10 transfers
    push_expected(model_str(3'd4, 5, 3, -2));
    @(posedge clk); #1;
    start = 1'b1; comparator = 3'd4; valc = 5; const1 = 3; const2 = -2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    check("pre_rst_left", exp_q.size(), 14);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", char_valid, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_stmt(3'd4, 5, 3, -2, 1'b0, dc);
    check("restart_done_cycle", dc, 25);

    // 6: loopback evaluation with x=7
    for (int c = 0; c < 6; c++) begin
      cap_q.delete();
      run_stmt(3'(c), 7, 1, -1, 1'b0, dc);
      check($sformatf("loop_p_cmp%0d", c), parse_p(cap_q, 7), exp_p[c]);
    end

    // random statements
    for (int it = 0; it < 30; it++) begin
      logic [2:0] cmp;
      int v, c1, c2;
      bit rnd;
      cmp = 3'($urandom_range(0, 5));
      v = pick_val(); c1 = pick_val(); c2 = pick_val();
      rnd = 1'($urandom_range(0, 1));
      s1 = model_str(cmp, v, c1, c2);
      run_stmt(cmp, v, c1, c2, rnd, dc);
      if (!rnd) check("rand_done_cycle", dc, s1.len() + 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
